// File: rtl/mux_arb_pkg.sv
// =============================================================================
// Module  : mux_arb_pkg
// Brief   : Shared constants, state type and helpers for the round-robin mux arbiter.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// =============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker: first set req bit at or after ptr.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest match overwrites.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// =============================================================================
// Module  : mux_rr_arbiter
// Brief   : Round-robin arbiter driving a shared 4:1 select with a registered
//           valid/ready output stage. Define ARB_STATS_EN for grant counters.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 1
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
`endif
);

    arb_state_t          state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                w_load;
    logic                w_found;
    logic [SEL_W-1:0]    w_idx;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A drain and a fresh capture share the same edge for full throughput.
    always_comb begin
        w_load  = (state_q == EMPTY) || (out_valid && out_ready);
        state_d = state_q;
        if (w_load) begin
            state_d = w_found ? FULL : EMPTY;
        end
    end

    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = data_q;
        grant     = grant_q;
        sel       = sel_q;
        ack       = ack_q;
    end

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ack_d   = '0;
        if (w_load) begin
            if (w_found) begin
                data_d  = in_data[w_idx*DATA_W +: DATA_W];
                grant_d = NUM_REQ'(1) << w_idx;
                sel_d   = onehot_to_idx(grant_d);
                ack_d   = grant_d;
                ptr_d   = w_idx + SEL_W'(1);
            end else begin
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            ack_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
        end
    end

`ifdef ARB_STATS_EN
    // Counters follow the visible ack pulse and stick at all-ones.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (ack_q[i] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// =============================================================================
// Module  : tb_mux_rr_arbiter
// Brief   : Self-checking bench for mux_rr_arbiter (vector table, random vs model,
//           grant counter saturation when ARB_STATS_EN is defined).
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

    localparam int DW       = 1;
    localparam int TB_CNT_W = 2;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] in_data;
    logic       out_ready;
    wire  [3:0] ack;
    wire  [3:0] grant;
    wire  [1:0] sel;
    wire  [0:0] out_data;
    wire        out_valid;
`ifdef ARB_STATS_EN
    wire  [4*TB_CNT_W-1:0] grant_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mux_rr_arbiter #(
        .DATA_W (DW)
`ifdef ARB_STATS_EN
        ,
        .CNT_W  (TB_CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .ack       (ack),
        .grant     (grant),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] data;
        logic       rdy;
        logic       v;
        logic       d;
        logic [3:0] g;
        logic [1:0] s;
        logic [3:0] a;
        logic       dchk;
    } vec_t;

    vec_t tbl [27];

    // Reference model state: plain integers, searched with modulo arithmetic.
    bit          m_full;
    bit          m_dknown;
    bit          m_data;
    int          m_owner;
    int          m_ptr;
    int          m_sel;
    bit [3:0]    m_ack;
    int          m_cnt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] d, input logic rd);
        rst       = r;
        req       = q;
        in_data   = d;
        out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input logic r, input logic [3:0] q, input logic [3:0] d, input logic rd);
        int win;
        if (r) begin
            m_full = 0; m_dknown = 1; m_data = 0; m_owner = -1;
            m_ptr = 0; m_sel = 0; m_ack = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_ack[i] && m_cnt[i] < (1 << TB_CNT_W) - 1) m_cnt[i]++;
            end
            m_ack = 0;
            if (!m_full || rd) begin
                win = -1;
                for (int k = 0; k < 4; k++) begin
                    if (win < 0 && q[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
                end
                if (win >= 0) begin
                    m_full = 1; m_dknown = 1; m_data = d[win];
                    m_owner = win; m_sel = win; m_ack[win] = 1'b1;
                    m_ptr = (win + 1) % 4;
                end else begin
                    m_full = 0; m_dknown = 0; m_owner = -1;
                end
            end
        end
    endtask

    task automatic model_check(input int cyc);
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk($sformatf("rnd%0d valid", cyc), 32'(out_valid), 32'(m_full));
        chk($sformatf("rnd%0d grant", cyc), 32'(grant), 32'(eg));
        chk($sformatf("rnd%0d sel", cyc), 32'(sel), 32'(m_sel));
        chk($sformatf("rnd%0d ack", cyc), 32'(ack), 32'(m_ack));
        if (m_dknown) chk($sformatf("rnd%0d data", cyc), 32'(out_data), 32'(m_data));
`ifdef ARB_STATS_EN
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rnd%0d cnt%0d", cyc, i), 32'(grant_cnt[i*TB_CNT_W +: TB_CNT_W]), 32'(m_cnt[i]));
        end
`endif
    endtask

    initial begin
        logic r, rd;
        logic [3:0] q, d;

        tbl[0]  = '{1'b1, 4'hF, 4'b1011, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b1};
        tbl[1]  = '{1'b0, 4'hF, 4'b1011, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1};
        tbl[2]  = '{1'b0, 4'hF, 4'b1011, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b1};
        tbl[3]  = '{1'b0, 4'hF, 4'b1011, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 4'b0100, 1'b1};
        tbl[4]  = '{1'b0, 4'hF, 4'b1011, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b1};
        tbl[5]  = '{1'b0, 4'hF, 4'b1011, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1};
        tbl[6]  = '{1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 4'h2, 4'b0010, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b1};
        for (int i = 8; i <= 11; i++)
            tbl[i] = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0000, 1'b1};
        tbl[12] = '{1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 4'b0000, 1'b0};
        tbl[13] = '{1'b0, 4'h8, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b1};
        tbl[14] = '{1'b0, 4'h9, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1};
        tbl[15] = '{1'b0, 4'h9, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b1};
        for (int i = 16; i <= 19; i++)
            tbl[i] = '{1'b0, 4'h4, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b1};
        tbl[20] = '{1'b0, 4'hF, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b1000, 2'd3, 4'b1000, 1'b1};
        tbl[21] = '{1'b0, 4'h2, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b1};
        tbl[22] = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0000, 1'b1};
        tbl[23] = '{1'b1, 4'hF, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b1};
        tbl[24] = '{1'b0, 4'hF, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1};
        tbl[25] = '{1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0};
        tbl[26] = '{1'b0, 4'h8, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b1};

        rst = 1'b1; req = '0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].data, tbl[i].rdy);
            chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("vec%0d sel", i), 32'(sel), 32'(tbl[i].s));
            chk($sformatf("vec%0d ack", i), 32'(ack), 32'(tbl[i].a));
            if (tbl[i].dchk) chk($sformatf("vec%0d data", i), 32'(out_data), 32'(tbl[i].d));
        end

`ifdef ARB_STATS_EN
        // Five grants to requester 1 saturate a 2-bit counter at 3.
        drive(1'b1, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 4'h2, 4'h2, 1'b1);
        drive(1'b0, 4'h0, 4'h0, 1'b1);
        drive(1'b0, 4'h0, 4'h0, 1'b1);
        chk("stats sat", 32'(grant_cnt), 32'(8'b00_00_11_00));
`endif

        model_edge(1'b1, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 4'h0, 4'h0, 1'b0);
        model_check(-1);
        for (int c = 0; c < 2000; c++) begin
            r  = ($urandom_range(0, 99) == 0);
            q  = 4'($urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) != 0);
            model_edge(r, q, d, rd);
            drive(r, q, d, rd);
            model_check(c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
